// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the IF (fetch) and MEM (data) ports.
// Optional fetch-starvation guard: define MEM_PORT_ARBITER_FAIR_EN.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ready,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_ready,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  stall_if,
   output logic                  stall_mem,
   output logic                  busy
);

   localparam int CW = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t          state;
   state_t          stateNext;
   logic [CW-1:0]   latCnt;
   logic            grantData;
   logic            reqAny;
   logic            pickData;
   logic            starved;
   logic            latDone;

   assign reqAny   = if_req | dm_req;
   assign latDone  = (latCnt == '0);
   assign pickData = dm_req & ~starved;

`ifdef MEM_PORT_ARBITER_FAIR_EN
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starveCnt;

   assign starved = if_req & (starveCnt == SW'(STARVE_LIMIT));

   // counts data grants that overtook a waiting fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starveCnt <= '0;
      end else if (state == IDLE && reqAny) begin
         if (pickData && if_req) begin
            starveCnt <= starveCnt + 1'b1;
         end else begin
            starveCnt <= '0;
         end
      end
   end
`else
   assign starved = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (reqAny) stateNext = ACCESS;
         ACCESS:  if (latDone) stateNext = RESP;
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         latCnt    <= '0;
         grantData <= 1'b0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (reqAny) begin
                  grantData <= pickData;
                  mem_en    <= 1'b1;
                  mem_we    <= pickData & dm_we;
                  mem_addr  <= pickData ? dm_addr : if_addr;
                  mem_wdata <= pickData ? dm_wdata : '0;
                  latCnt    <= CW'(MEM_LATENCY);
               end
            end
            ACCESS: begin
               if (latDone) begin
                  if (grantData) begin
                     dm_rdata <= mem_rdata;
                  end else begin
                     if_rdata <= mem_rdata;
                  end
                  dm_ready <= grantData;
                  if_ready <= ~grantData;
               end else begin
                  latCnt <= latCnt - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // rst_n gating keeps stalls low while reset is held
   assign stall_if  = rst_n & if_req & ~if_ready;
   assign stall_mem = rst_n & dm_req & ~dm_ready;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Fairness expectations follow MEM_PORT_ARBITER_FAIR_EN.
module tb_mem_port_arbiter;

   localparam int L  = 2;
   localparam int SL = 2;
   localparam int P  = L + 3;

   typedef struct {
      bit          isData;
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
      int          enCyc;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;
   logic        busy;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   enCnt = 0;
   int   readyCnt = 0;
   int   age = 0;
   logic [31:0] mAddr = '0;
   acc_t q[$];
   acc_t monE;

   mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .MEM_LATENCY(L), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memVal(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]} ^ 32'h1357_2468;
   endfunction

   // memory data is valid only in the cycle L after the strobe
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age <= 0;
      end else if (mem_en) begin
         age   <= 1;
         mAddr <= mem_addr;
      end else if (age != 0 && age < 16) begin
         age <= age + 1;
      end
   end

   assign mem_rdata = (age == L) ? memVal(mAddr) : 32'hBAD0BAD0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cyc %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (!mem_en) chk("weNoEn", mem_we, 0);
         if (mem_en) begin
            enCnt++;
            if (q.size() == 0) begin
               chk("spuriousEn", 1, 0);
            end else begin
               chk("enCyc", cyc, q[0].enCyc);
               chk("memAddr", mem_addr, q[0].addr);
               chk("memWe", mem_we, q[0].we);
               if (q[0].we) chk("memWdata", mem_wdata, q[0].wdata);
            end
         end
         if (if_ready || dm_ready) begin
            readyCnt++;
            if (q.size() == 0) begin
               chk("spuriousRdy", 1, 0);
            end else begin
               monE = q.pop_front();
               chk("port", dm_ready, monE.isData);
               chk("bothRdy", if_ready & dm_ready, 0);
               chk("rdyCyc", cyc, monE.enCyc + L + 1);
               if (!monE.isData)
                  chk("ifRdata", if_rdata, memVal(monE.addr));
               else if (!monE.we)
                  chk("dmRdata", dm_rdata, memVal(monE.addr));
            end
         end
      end
   end

   task automatic push(input bit isData, input logic [31:0] a,
                       input bit we, input logic [31:0] wd,
                       input int enCyc);
      acc_t e;
      e.isData = isData;
      e.addr   = a;
      e.we     = we;
      e.wdata  = wd;
      e.enCyc  = enCyc;
      q.push_back(e);
   endtask

   task automatic startCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic waitEmpty(input int bound);
      for (int i = 0; i < bound; i++) begin
         startCycle();
         if (q.size() == 0) return;
      end
      chk("timeout", q.size(), 0);
   endtask

   task automatic dropOnReady(input bit isData);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (isData ? dm_ready : if_ready) begin
            if (isData) dm_req = 1'b0;
            else if_req = 1'b0;
            return;
         end
      end
      chk("rdyTimeout", 0, 1);
      if (isData) dm_req = 1'b0;
      else if_req = 1'b0;
   endtask

   task automatic single(input bit isData, input logic [31:0] a,
                         input bit we, input logic [31:0] wd);
      startCycle();
      push(isData, a, we, wd, cyc + 1);
      if (isData) begin
         dm_req = 1'b1; dm_addr = a; dm_we = we; dm_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = a;
      end
      for (int k = 0; k <= L + 2; k++) begin
         @(negedge clk);
         chk(isData ? "stallMem" : "stallIf",
             isData ? stall_mem : stall_if, k < L + 2);
      end
      if (isData) dm_req = 1'b0;
      else if_req = 1'b0;
      waitEmpty(40);
   endtask

   initial begin
      int c0;
      int n;
      int r0;
      bit d;

      // reset held with both requests active
      if_req = 1'b1; if_addr = 32'h44;
      dm_req = 1'b1; dm_we = 1'b1;
      dm_addr = 32'h88; dm_wdata = 32'hFFFF;
      repeat (3) @(negedge clk);
      chk("rstMemEn", mem_en, 0);
      chk("rstMemWe", mem_we, 0);
      chk("rstMemAddr", mem_addr, 0);
      chk("rstMemWdata", mem_wdata, 0);
      chk("rstIfRdy", if_ready, 0);
      chk("rstDmRdy", dm_ready, 0);
      chk("rstIfRdata", if_rdata, 0);
      chk("rstDmRdata", dm_rdata, 0);
      chk("rstBusy", busy, 0);
      chk("rstStallIf", stall_if, 0);
      chk("rstStallMem", stall_mem, 0);
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      startCycle();
      rst_n = 1'b1;
      r0 = enCnt;
      repeat (20) @(negedge clk);
      chk("idleNoEn", enCnt, r0);
      chk("idleBusy", busy, 0);

      // single fetch and data accesses
      single(1'b0, 32'h100, 1'b0, 32'h0);
      single(1'b1, 32'h20, 1'b1, 32'h12345678);
      single(1'b1, 32'h24, 1'b0, 32'h0);
      single(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);

      // simultaneous: data first, fetch one period later
      startCycle();
      c0 = cyc;
      push(1'b1, 32'h80, 1'b0, 32'h0, c0 + 1);
      push(1'b0, 32'h40, 1'b0, 32'h0, c0 + 1 + P);
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_addr = 32'h80; dm_we = 1'b0;
      fork
         dropOnReady(1'b1);
         dropOnReady(1'b0);
      join
      waitEmpty(40);

      // both requests held continuously
      startCycle();
      c0 = cyc;
`ifdef MEM_PORT_ARBITER_FAIR_EN
      n = 6;
`else
      n = 10;
`endif
      for (int k = 0; k < n; k++) begin
`ifdef MEM_PORT_ARBITER_FAIR_EN
         d = (k % (SL + 1)) != SL;
`else
         d = 1'b1;
`endif
         push(d, d ? 32'h300 : 32'h200, 1'b0, 32'h0, c0 + 1 + k * P);
      end
      if_req = 1'b1; if_addr = 32'h200;
      dm_req = 1'b1; dm_addr = 32'h300; dm_we = 1'b0;
      waitEmpty(n * P + 20);
      if_req = 1'b0; dm_req = 1'b0;
      repeat (3) startCycle();

      // reset in the middle of an access
      startCycle();
      push(1'b0, 32'h500, 1'b0, 32'h0, cyc + 1);
      if_req = 1'b1; if_addr = 32'h500;
      repeat (2) startCycle();
      chk("preRstBusy", busy, 1);
      chk("preRstAddr", mem_addr, 32'h500);
      r0 = readyCnt;
      rst_n = 1'b0;
      #1;
      chk("midRstBusy", busy, 0);
      chk("midRstAddr", mem_addr, 0);
      chk("midRstEn", mem_en, 0);
      chk("midRstStall", stall_if, 0);
      q.delete();
      if_req = 1'b0;
      repeat (2) startCycle();
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("noRdyAfterRst", readyCnt, r0);
      chk("postRstBusy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1);
   end

endmodule
